// File: rtl/inside_table_loader_if.sv
// rtl/inside_table_loader_if.sv - handshake/bus bundle for inside_table_loader
//
// Groups the table-write stream, sample stream, registered output stream
// and table/status outputs. The slave modport is the loader's view; the
// master modport is the view of whatever drives it.
interface inside_table_loader_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
);
    logic                     load_start;
    logic                     wr_valid;
    logic [WIDTH-1:0]         wr_data;
    logic                     wr_ready;
    logic                     smp_valid;
    logic [WIDTH-1:0]         smp_data;
    logic                     smp_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_A;
    logic                     out_ready;
    logic [DEPTH*WIDTH-1:0]   values_flat;
    logic                     armed;
    logic                     load_err;

    modport slave (
        input  load_start, wr_valid, wr_data, smp_valid, smp_data, out_ready,
        output wr_ready, smp_ready, out_valid, out_A, values_flat, armed, load_err
    );

    modport master (
        output load_start, wr_valid, wr_data, smp_valid, smp_data, out_ready,
        input  wr_ready, smp_ready, out_valid, out_A, values_flat, armed, load_err
    );
endinterface

// File: rtl/inside_table_loader.sv
// rtl/inside_table_loader.sv - set-table loader feeding a membership checker
//
// Purpose: programs a DEPTH-entry value table from a write stream, then
// forwards samples through a one-entry output register once the table is full.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - inside_table_loader_if.slave (load_start, wr_*, smp_*, out_*,
//          values_flat, armed, load_err)
// Optional feature macro: INSIDE_DUP_CHECK_EN (drop duplicate table writes
// and raise sticky load_err).
module inside_table_loader #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    inside_table_loader_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_entries [DEPTH];
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_a;
    logic               w_wr_ready;
    logic               w_smp_ready;
    logic               w_dup;
    logic               w_wr_store;

`ifdef INSIDE_DUP_CHECK_EN
    logic               r_load_err;

    // Compare the incoming word against the entries already written this load.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) < r_idx && r_entries[i] == bus.wr_data) begin
                w_dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_err <= 1'b0;
        end else if (bus.load_start) begin
            r_load_err <= 1'b0;
        end else if (r_state == LOAD && bus.wr_valid && w_dup) begin
            r_load_err <= 1'b1;
        end
    end

    assign bus.load_err = r_load_err;
`else
    assign w_dup        = 1'b0;
    assign bus.load_err = 1'b0;
`endif

    // A write is stored only if it is accepted, not pre-empted by load_start
    // and not a duplicate.
    assign w_wr_store = (r_state == LOAD) && bus.wr_valid && !bus.load_start && !w_dup;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_ready   = 1'b0;
        w_smp_ready  = 1'b0;
        case (r_state)
            IDLE: begin
            end
            LOAD: begin
                w_wr_ready = 1'b1;
                if (bus.wr_valid && !w_dup && r_idx == IDX_W'(DEPTH - 1)) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                w_smp_ready = !r_out_valid || bus.out_ready;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (bus.load_start) begin
            w_state_next = LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (bus.load_start) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_store) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        r_entries[i] <= bus.wr_data;
                    end
                end
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ARMED) begin
                if (bus.smp_valid && w_smp_ready) begin
                    r_out_a     <= bus.smp_data;
                    r_out_valid <= 1'b1;
                end else if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign bus.values_flat[g*WIDTH +: WIDTH] = r_entries[g];
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.smp_ready = w_smp_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_A     = r_out_a;
    assign bus.armed     = (r_state == ARMED);
endmodule

// File: tb/tb_inside_table_loader.sv
// tb/tb_inside_table_loader.sv - directed self-checking bench for inside_table_loader
module tb_inside_table_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    inside_table_loader_if #(.DEPTH(4), .WIDTH(8)) bus ();

    inside_table_loader #(.DEPTH(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic wr(input logic [7:0] v);
        bus.wr_valid = 1'b1;
        bus.wr_data  = v;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.smp_valid  = 1'b0;
        bus.smp_data   = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_values", bus.values_flat, 64'h0);
        chk("rst_armed", bus.armed, 1'b0);
        chk("rst_wr_ready", bus.wr_ready, 1'b0);
        chk("rst_smp_ready", bus.smp_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_load_err", bus.load_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Samples ignored in IDLE
        bus.smp_valid = 1'b1;
        bus.smp_data  = 8'd33;
        #1 chk("idle_smp_ready", bus.smp_ready, 1'b0);
        tick();
        chk("idle_out_valid", bus.out_valid, 1'b0);
        bus.smp_valid = 1'b0;

        // Basic load: 100,110,120,130
        pulse_load();
        chk("load_wr_ready", bus.wr_ready, 1'b1);
        chk("load_armed", bus.armed, 1'b0);
        wr(8'd100);
        chk("w1_values", bus.values_flat, 64'h64);
        wr(8'd110);
        wr(8'd120);
        chk("w3_armed", bus.armed, 1'b0);
        bus.smp_valid = 1'b1;
        #1 chk("load_smp_ready", bus.smp_ready, 1'b0);
        bus.smp_valid = 1'b0;
        wr(8'd130);
        chk("w4_values", bus.values_flat, 64'h82786E64);
        chk("w4_armed", bus.armed, 1'b1);
        chk("armed_wr_ready", bus.wr_ready, 1'b0);

        // Back-to-back samples with out_ready held high
        bus.out_ready = 1'b1;
        bus.smp_valid = 1'b1;
        bus.smp_data  = 8'd110;
        #1 chk("b2b_smp_ready", bus.smp_ready, 1'b1);
        tick();
        chk("b2b_a0", bus.out_A, 8'd110);
        chk("b2b_v0", bus.out_valid, 1'b1);
        bus.smp_data = 8'd50;
        tick();
        chk("b2b_a1", bus.out_A, 8'd50);
        chk("b2b_v1", bus.out_valid, 1'b1);
        bus.smp_data = 8'd130;
        tick();
        chk("b2b_a2", bus.out_A, 8'd130);
        chk("b2b_v2", bus.out_valid, 1'b1);
        bus.smp_valid = 1'b0;
        tick();
        chk("b2b_drain", bus.out_valid, 1'b0);

        // Backpressure: 120 held, 99 waits
        bus.out_ready = 1'b0;
        bus.smp_valid = 1'b1;
        bus.smp_data  = 8'd120;
        tick();
        chk("bp_a0", bus.out_A, 8'd120);
        bus.smp_data = 8'd99;
        #1 chk("bp_ready0", bus.smp_ready, 1'b0);
        @(negedge clk);
        tick();
        chk("bp_hold_a", bus.out_A, 8'd120);
        chk("bp_hold_v", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        #1 chk("bp_ready1", bus.smp_ready, 1'b1);
        @(negedge clk);
        chk("bp_a1", bus.out_A, 8'd99);
        chk("bp_v1", bus.out_valid, 1'b1);
        bus.smp_valid = 1'b0;
        tick();
        chk("bp_drain", bus.out_valid, 1'b0);

        // Reload pre-empting a write
        pulse_load();
        chk("reload_armed", bus.armed, 1'b0);
        wr(8'd1);
        wr(8'd2);
        bus.load_start = 1'b1;
        bus.wr_valid   = 1'b1;
        bus.wr_data    = 8'd77;
        tick();
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        chk("pre_values", bus.values_flat, 64'h82780201);
        wr(8'd5);
        wr(8'd6);
        wr(8'd7);
        chk("pre_w3_values", bus.values_flat, 64'h82070605);
        chk("pre_w3_armed", bus.armed, 1'b0);
        wr(8'd8);
        chk("pre_w4_values", bus.values_flat, 64'h08070605);
        chk("pre_w4_armed", bus.armed, 1'b1);

        // Duplicate handling
        pulse_load();
        wr(8'd100);
        wr(8'd100);
`ifdef INSIDE_DUP_CHECK_EN
        chk("dup_err", bus.load_err, 1'b1);
        wr(8'd110);
        wr(8'd120);
        chk("dup_w4_armed", bus.armed, 1'b0);
        wr(8'd130);
        chk("dup_values", bus.values_flat, 64'h82786E64);
        chk("dup_armed", bus.armed, 1'b1);
        chk("dup_err_sticky", bus.load_err, 1'b1);
        pulse_load();
        chk("dup_err_clr", bus.load_err, 1'b0);
        wr(8'd100);
        wr(8'd110);
        wr(8'd120);
        wr(8'd130);
`else
        chk("nodup_err", bus.load_err, 1'b0);
        wr(8'd110);
        wr(8'd120);
        chk("nodup_values", bus.values_flat, 64'h786E6464);
        chk("nodup_armed", bus.armed, 1'b1);
`endif

        // Asynchronous reset while holding a sample
        bus.out_ready = 1'b0;
        bus.smp_valid = 1'b1;
        bus.smp_data  = 8'd42;
        tick();
        bus.smp_valid = 1'b0;
        chk("pre_rst_v", bus.out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_v", bus.out_valid, 1'b0);
        chk("arst_armed", bus.armed, 1'b0);
        chk("arst_values", bus.values_flat, 64'h0);
        chk("arst_a", bus.out_A, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_wr_ready", bus.wr_ready, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/inside_table_loader.md
INSIDE_TABLE_LOADER -- requirements
Module: inside_table_loader

Interface
REQ-001 Parameter: DEPTH, default 4, number of set-table entries.
REQ-002 Parameter: WIDTH, default 8, bit width of each table entry and each sample.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  one-cycle pulse; (re)starts table programming.
REQ-006 wr_valid  input  1  table-write word valid.
REQ-007 wr_data  input  WIDTH  table-write word.
REQ-008 wr_ready  output  1  table-write word accepted when wr_valid&wr_ready.
REQ-009 smp_valid  input  1  candidate sample valid.
REQ-010 smp_data  input  WIDTH  candidate sample value.
REQ-011 smp_ready  output  1  sample accepted when smp_valid&smp_ready.
REQ-012 out_valid  output  1  registered sample presented to the downstream membership checker.
REQ-013 out_A  output  WIDTH  sample value for the checker's A input.
REQ-014 out_ready  input  1  checker consumes out_A when out_valid&out_ready.
REQ-015 values_flat  output  DEPTH*WIDTH  table contents; entry i at bits [i*WIDTH +: WIDTH].
REQ-016 armed  output  1  high while the table is complete and samples flow.
REQ-017 load_err  output  1  sticky duplicate-value flag (see Configuration).

Function
REQ-018 FSM states: IDLE, LOAD, ARMED; reset state IDLE.
REQ-019 IDLE: wr_ready=0, smp_ready=0; load_start -> LOAD with write index idx=0.
REQ-020 LOAD: wr_ready=1; each accepted write stores wr_data into entry idx, idx increments by 1.
REQ-021 LOAD: the write that fills entry DEPTH-1 transitions to ARMED on the same edge; armed=1 from the next cycle.
REQ-022 idx is wide enough for DEPTH; it never wraps inside LOAD.
REQ-023 ARMED: one-entry output register; smp_ready = !out_valid | out_ready (combinational).
REQ-024 ARMED: accepted sample appears on out_A with out_valid=1 one cycle later; latency 1, throughput 1 per cycle under continuous out_ready.
REQ-025 out_A and out_valid hold stable while out_valid&!out_ready.
REQ-026 load_start in any state: -> LOAD, idx=0, out_valid cleared, armed=0 on the next edge; table entries keep old values until overwritten.
REQ-027 load_start and an accepted write in the same cycle: load_start wins; write discarded, idx=0.
REQ-028 smp_valid outside ARMED: ignored, smp_ready=0; out_valid remains 0.
REQ-029 values_flat updates the cycle after each accepted write.

Reset
REQ-030 RST asserted: state IDLE, idx=0, all table entries 0, out_valid=0, out_A=0, armed=0, load_err=0, wr_ready=0, smp_ready=0.
REQ-031 RST mid-LOAD or mid-ARMED aborts immediately; partially loaded entries are cleared to 0.

Configuration
REQ-032 Macro INSIDE_DUP_CHECK_EN defined: in LOAD, a write whose wr_data equals any entry 0..idx-1 is accepted (handshake completes) but not stored, idx unchanged, load_err set to 1 until the next load_start or RST.
REQ-033 INSIDE_DUP_CHECK_EN undefined: all writes stored regardless of value; load_err tied to 0.

Verification
REQ-034 RST, load_start, writes 100,110,120,130 -> values_flat=0x82786E64, armed=1 one cycle after 4th write.
REQ-035 Armed, out_ready=1, samples 110,50,130 back-to-back -> out_A 110,50,130 on consecutive cycles, out_valid continuously 1.
REQ-036 Armed, out_ready=0, sample 120 then 99 offered -> out_A holds 120, smp_ready=0 until out_ready=1, then 99 follows next cycle.
REQ-037 LOAD after 2 writes, load_start with wr_valid=1 -> write dropped, idx=0, 4 further writes required to reach ARMED.
REQ-038 INSIDE_DUP_CHECK_EN: writes 100,100,110,120,130 -> load_err=1 after 2nd write, table 100,110,120,130, armed after 5th write.
REQ-039 RST pulsed while out_valid=1 in ARMED -> out_valid=0, armed=0, values_flat=0 immediately (asynchronous).
